// File: rtl/uart_pkg.sv
// Shared UART definitions: LSR bit positions, FIFO trigger-level encodings and
// the clock/baud defaults from which the receive character timeout is derived.
package uart_pkg;

  localparam int LSR_DR   = 0;
  localparam int LSR_OE   = 1;
  localparam int LSR_THRE = 5;
  localparam int LSR_TEMT = 6;

  typedef enum logic [1:0] {
    TRIG_1        = 2'd0,
    TRIG_4        = 2'd1,
    TRIG_8        = 2'd2,
    TRIG_DEPTH_M2 = 2'd3
  } trig_sel_e;

  localparam int SYSCLK_MHZ    = 27;
  localparam int BAUD_RATE     = 115200;
  localparam int TIMEOUT_CHARS = 4;
  localparam int BITS_PER_CHAR = 10;

  // Four 10-bit characters of idle line, expressed in system clock cycles.
  localparam int TIMEOUT_CYCLES =
    TIMEOUT_CHARS * BITS_PER_CHAR * SYSCLK_MHZ * 1_000_000 / BAUD_RATE;

  function automatic int trig_threshold(input logic [1:0] sel, input int depth);
    case (trig_sel_e'(sel))
      TRIG_1:  return 1;
      TRIG_4:  return 4;
      TRIG_8:  return 8;
      default: return depth - 2;
    endcase
  endfunction

endpackage

// File: rtl/uart_fifo_ram.sv
// DEPTH x 8 receive FIFO storage: synchronous write, registered synchronous read
// whose output register is the FIFO's dout.
module uart_fifo_ram #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    dout
);

  logic [7:0] mem [DEPTH];

  // NOTE: the array has no reset so it maps onto plain RAM; the pointers and
  // level counter alone decide which entries are meaningful.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // A write and a read of the same slot in one cycle return the old byte,
  // which is what a full FIFO doing push+pop needs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     dout <= '0;
    else if (rd_en) dout <= mem[rd_addr];
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO with level, data-ready, overrun and trigger-level status.
// Define UART_RX_TIMEOUT_EN to build the character-timeout idle counter.
module uart_rx_fifo #(
  parameter int DEPTH          = 16,
  parameter int AW             = 4,
  parameter int TIMEOUT_CYCLES = uart_pkg::TIMEOUT_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_rdy,
  input  logic [7:0]  rx_data,
  input  logic        pop,
  input  logic        flush,
  input  logic        clr_overrun,
  input  logic [1:0]  trig_sel,
  output logic [7:0]  dout,
  output logic        data_ready,
  output logic [AW:0] level,
  output logic        overrun,
  output logic        trig_irq,
  output logic        timeout_irq
);

  import uart_pkg::*;

  localparam logic [AW-1:0] PTR_ONE    = 1;
  localparam logic [AW:0]   LVL_ONE    = 1;
  localparam logic [AW:0]   FULL_LEVEL = (AW+1)'(DEPTH);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          push_ok;
  logic          pop_ok;
  logic          overrun_set;
  logic [AW:0]   threshold;

  assign full       = (level == FULL_LEVEL);
  assign data_ready = (level != '0);

  // Flush wins over everything; a full FIFO still takes a byte when a pop
  // frees a slot in the same cycle.
  assign pop_ok      = pop && data_ready && !flush;
  assign push_ok     = rx_rdy && !flush && (!full || pop_ok);
  assign overrun_set = rx_rdy && !flush && !push_ok;

  assign threshold = (AW+1)'(trig_threshold(trig_sel, DEPTH));
  assign trig_irq  = (level >= threshold);

  // NOTE: sequential state is written only with non-blocking assignments so
  // every register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
      if (push_ok && !pop_ok)      level <= level + LVL_ONE;
      else if (pop_ok && !push_ok) level <= level - LVL_ONE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)           overrun <= 1'b0;
    else if (overrun_set) overrun <= 1'b1;
    else if (clr_overrun) overrun <= 1'b0;
  end

  uart_fifo_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (push_ok),
    .wr_addr (wr_ptr),
    .wr_data (rx_data),
    .rd_en   (pop_ok),
    .rd_addr (rd_ptr),
    .dout    (dout)
  );

`ifdef UART_RX_TIMEOUT_EN
  localparam logic [13:0] TIMEOUT_MAX = 14'(TIMEOUT_CYCLES);

  logic [13:0] idle_cnt;

  // Counts cycles with bytes waiting and no FIFO activity, parking at the limit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                     idle_cnt <= '0;
    else if (push_ok || pop_ok || flush || !data_ready) idle_cnt <= '0;
    else if (idle_cnt != TIMEOUT_MAX)               idle_cnt <= idle_cnt + 14'd1;
  end

  assign timeout_irq = (idle_cnt == TIMEOUT_MAX) && data_ready;
`else
  assign timeout_irq = 1'b0;
`endif

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side buffer between the serial UART core and the UART register controller. It captures each byte strobed out by the serial receiver into a DEPTH-entry FIFO. It hands bytes to the controller one at a time on read of RBR and reports level, data-ready, overrun, trigger-level and character-timeout status, so the controller can present a 16550-style LSR/IIR. Single clock domain.

## Interface
Parameters:
- DEPTH, 16, FIFO entries; power of two, ≥4
- AW, 4, log2(DEPTH)
- TIMEOUT_CYCLES, 9375, idle cycles before character timeout (4 chars at 115200 baud / 27 MHz)

Ports (reset is `reset`, asynchronous, active-low; clock is `clk`):
- clk  in  1  system clock
- reset  in  1  asynchronous active-low reset
- rx_rdy  in  1  one-cycle strobe from serial core, rx_data valid
- rx_data  in  8  received byte
- pop  in  1  controller reads RBR; one-cycle strobe
- flush  in  1  FCR receive-FIFO clear; one-cycle strobe
- clr_overrun  in  1  controller read of LSR; clears overrun
- trig_sel  in  2  FCR[7:6] trigger select
- dout  out  8  byte popped, registered
- data_ready  out  1  FIFO non-empty (LSR.DR)
- level  out  AW+1  entries held, 0..DEPTH
- overrun  out  1  sticky overrun (LSR.OE)
- trig_irq  out  1  level ≥ selected threshold
- timeout_irq  out  1  character timeout pending

## Operation
- Storage: DEPTH×8 array, wr_ptr/rd_ptr AW bits, wrap modulo DEPTH; level is an AW+1 counter, the sole full/empty source (full = level==DEPTH).
- Push: rx_rdy && !full → mem[wr_ptr]<=rx_data, wr_ptr++, level++.
- Pop: pop && level!=0 → dout<=mem[rd_ptr], rd_ptr++, level--. Pop when empty ignored; dout holds.
- Simultaneous push+pop, non-empty: both happen, level unchanged. If full, push accepted (slot freed same cycle), no overrun. If empty, only push takes effect.
- Overrun: rx_rdy while full and no pop → byte dropped, overrun<=1. Cleared only by clr_overrun or reset; a set in the same cycle as clr_overrun wins.
- Flush: pointers and level to 0, timeout cleared; overrun and dout unchanged; flush beats push/pop in the same cycle (byte dropped, no overrun).
- Threshold: trig_sel 0→1, 1→4, 2→8, 3→DEPTH-2. trig_irq = (level ≥ threshold), combinational from level register.
- data_ready = (level != 0).

## Timing
- Reset values: dout 0, level 0, data_ready 0, overrun 0, trig_irq 0, timeout_irq 0, pointers 0, timeout counter 0.
- rx_rdy in cycle N → level/data_ready updated at N+1; the byte can be popped at N+1 and appears on dout at N+2.
- pop in cycle N → dout valid at N+1, level decremented at N+1.
- Back-to-back pops every cycle are legal at full throughput.
- Reset mid-operation: all contents discarded and outputs return to reset values asynchronously.

## Configuration
- UART_RX_TIMEOUT_EN defined: a 14-bit idle counter runs.
  - Counter clears on push, pop, flush, or when empty; otherwise increments, saturating at TIMEOUT_CYCLES.
  - timeout_irq = (counter == TIMEOUT_CYCLES) && data_ready.
  - Drops the cycle after the next push, pop or flush.
- Undefined: no counter; timeout_irq tied 0.

## Structure
- Shared package uart_pkg holds:
  - LSR bit positions (DR, OE, THRE, TEMT)
  - trig_sel encodings and threshold function
  - default SYSCLK_MHZ=27 and BAUD_RATE=115200
  - derived TIMEOUT_CYCLES
- One sub-module, uart_fifo_ram: DEPTH×8 storage, synchronous write, synchronous registered read feeding dout. Pointer/level/flag logic stays in uart_rx_fifo.

## Test plan
- Reset, then 3 rx_rdy strobes 0x41,0x42,0x43 → level=3, data_ready=1; three pops → dout 0x41,0x42,0x43 on successive cycles, level=0, data_ready=0.
- Fill 16 bytes 0x00..0x0F, 17th strobe 0xFF → level=16, overrun=1; drain yields 0x00..0x0F (0xFF absent); clr_overrun → overrun=0.
- At level=16, rx_rdy+pop same cycle with 0xAA → no overrun, level stays 16; the last byte drained is 0xAA.
- trig_sel=1: after 3 pushes trig_irq=0, after 4th trig_irq=1; trig_sel=3 requires level 14.
- Level 5, flush with simultaneous rx_rdy 0x55 and pop → level=0, data_ready=0, overrun unchanged, dout unchanged, 0x55 not stored.
- UART_RX_TIMEOUT_EN: push one byte, idle 9375 cycles → timeout_irq=1; pop → timeout_irq=0 next cycle. Without macro, timeout_irq remains 0.
